// File: rtl/reset_cmd_pkg.sv
// Purpose : shared constants for the reset-command transmitter (magic frame, FSM states).
// Latency : n/a (package).
// Backpressure: n/a; holds the 5-byte magic sequence, its length and the sequencer state enum.
package reset_cmd_pkg;

    localparam int FRAME_LEN = 5;

    // Byte sequence that makes the far-end detector pulse its reset.
    localparam logic [7:0] MAGIC [FRAME_LEN] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};

    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_GAP    = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    // Constant-index lookup keeps the select free of out-of-range reads.
    function automatic logic [7:0] magic_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return MAGIC[0];
            3'd1:    return MAGIC[1];
            3'd2:    return MAGIC[2];
            3'd3:    return MAGIC[3];
            3'd4:    return MAGIC[4];
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/reset_cmd_tx_if.sv
// Purpose : command/status bundle of reset_cmd_tx (start request, serial line, busy, done).
// Latency : n/a (wires only).
// Backpressure: none; start is dropped unless the transmitter is idle.
interface reset_cmd_tx_if;
    logic start;
    logic txd;
    logic busy;
    logic done;

    modport master (output start, input txd, input busy, input done);
    modport slave  (input start, output txd, output busy, output done);
endinterface

// File: rtl/uart_tx_byte.sv
// Purpose : generic 8N1 UART byte serializer; ports clk, rst_n, load, data[7:0] in; txd, tx_done out.
// Latency : txd start bit appears the cycle after load; 10*CLKS_PER_BIT cycles per byte.
// Backpressure: none; a load while active restarts the byte. tx_done is high in the last stop-bit cycle.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       txd,
    output logic       tx_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] clk_cnt;
    logic [3:0]    bit_idx;   // 0 = start bit, 1..8 = data, 9 = stop bit
    logic [8:0]    shreg;     // remaining data bits followed by the stop bit
    logic          active;
    logic          bit_end;

    assign bit_end = (clk_cnt == LAST_CNT);
    // Combinational so the sequencer can leave SHIFT right after the stop bit.
    assign tx_done = active && bit_end && (bit_idx == 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txd     <= 1'b1;
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '1;
            active  <= 1'b0;
        end else if (load) begin
            active  <= 1'b1;
            txd     <= 1'b0;
            shreg   <= {1'b1, data};
            clk_cnt <= '0;
            bit_idx <= '0;
        end else if (active) begin
            if (bit_end) begin
                clk_cnt <= '0;
                if (bit_idx == 4'd9) begin
                    active  <= 1'b0;
                    txd     <= 1'b1;
                    bit_idx <= '0;
                end else begin
                    txd     <= shreg[0];
                    shreg   <= {1'b1, shreg[8:1]};
                    bit_idx <= bit_idx + 4'd1;
                end
            end else begin
                clk_cnt <= clk_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/reset_cmd_tx.sv
// Purpose : sends the 5-byte remote-reset command (AA BB CC DD EE) over UART; ports clk, rst_n, bus (start/txd/busy/done).
// Latency : busy the cycle after start is taken, start bit one cycle later; GAP_CYCLES+1 idle cycles between bytes.
// Backpressure: start is ignored while busy and in the done cycle; no queuing.
module reset_cmd_tx
    import reset_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int GAP_CYCLES   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reset_cmd_tx_if.slave        bus
);

    localparam logic [15:0] GAP_LAST = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

    state_e      state;
    logic [2:0]  byte_idx;
    logic [15:0] gap_cnt;
    logic        load;
    logic        tx_done;
    logic        txd_int;

    // LOAD is itself one idle-high cycle before each start bit.
    assign load = (state == ST_LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            byte_idx <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (tx_done) begin
                        if (byte_idx == LAST_IDX) begin
                            state <= ST_FINISH;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            gap_cnt  <= '0;
                            state    <= (GAP_CYCLES > 0) ? ST_GAP : ST_LOAD;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) state <= ST_LOAD;
                    else                     gap_cnt <= gap_cnt + 16'd1;
                end
                ST_FINISH: begin
                    byte_idx <= '0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .data    (magic_byte(byte_idx)),
        .txd     (txd_int),
        .tx_done (tx_done)
    );

    assign bus.txd  = txd_int;
    assign bus.busy = (state == ST_LOAD) || (state == ST_SHIFT) || (state == ST_GAP);
    assign bus.done = (state == ST_FINISH);

endmodule

// File: tb/tb_reset_cmd_tx.sv
// Purpose : directed self-checking bench for reset_cmd_tx (CLKS_PER_BIT=4, GAP 2 and GAP 0 instances).
// Latency : n/a.
// Backpressure: n/a.
module tb_reset_cmd_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    reset_cmd_tx_if if_a ();
    reset_cmd_tx_if if_b ();

    reset_cmd_tx #(.CLKS_PER_BIT(4), .GAP_CYCLES(2)) dut_a (
        .clk (clk), .rst_n (rst_n), .bus (if_a.slave)
    );
    reset_cmd_tx #(.CLKS_PER_BIT(4), .GAP_CYCLES(0)) dut_b (
        .clk (clk), .rst_n (rst_n), .bus (if_b.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] exp_bytes [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};

    // Per-cycle capture, index 0 = first cycle after the edge that sampled start.
    logic ct [2][1024];
    logic cb [2][1024];
    logic cd [2][1024];

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic drive_start(input int sel, input logic v);
        if (sel == 0) if_a.start = v;
        else          if_b.start = v;
    endtask

    // Samples both DUTs at each falling edge; start on 'sel' is held for
    // the first 'hold' samples and pulsed after samples p0/p1/p2.
    task automatic capture(input int n, input int sel, input int hold,
                           input int p0, input int p1, input int p2);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ct[0][i] = if_a.txd; cb[0][i] = if_a.busy; cd[0][i] = if_a.done;
            ct[1][i] = if_b.txd; cb[1][i] = if_b.busy; cd[1][i] = if_b.done;
            drive_start(sel, (i < hold) || (i == p0) || (i == p1) || (i == p2));
        end
        drive_start(sel, 1'b0);
    endtask

    // Decodes one frame from the capture and checks bytes, gaps, frame time,
    // done pulse and busy window.
    task automatic analyze(input int s, input int gap, input int n, input string tg);
        int first, p, q, dcnt, didx, bcnt, ftime;
        logic [7:0] rx;
        first = -1;
        for (int i = 0; i < n; i++) if (ct[s][i] == 1'b0) begin first = i; break; end
        chk({tg, "_first_low"}, first, 1);
        if (first < 0) return;
        p = first;
        for (int b = 0; b < 5; b++) begin
            for (int k = 0; k < 8; k++) rx[k] = ct[s][p + 4*(k+1) + 2];
            chk($sformatf("%s_start%0d", tg, b), int'(ct[s][p+2]), 0);
            chk($sformatf("%s_byte%0d", tg, b), int'(rx), int'(exp_bytes[b]));
            chk($sformatf("%s_stop%0d", tg, b), int'(ct[s][p+38]), 1);
            if (b < 4) begin
                q = -1;
                for (int i = p + 40; i < n; i++) if (ct[s][i] == 1'b0) begin q = i; break; end
                chk($sformatf("%s_idle%0d", tg, b), q - (p + 40), gap + 1);
                if (q < 0) return;
                p = q;
            end
        end
        // Last stop-bit cycle is p+39, so frame time is (p+40)-first.
        ftime = 200 + 4*(gap + 1);
        chk({tg, "_frame_time"}, p + 40 - first, ftime);
        dcnt = 0; didx = -1; bcnt = 0;
        for (int i = 0; i < n; i++) begin
            if (cd[s][i]) begin dcnt++; didx = i; end
            if (cb[s][i]) bcnt++;
        end
        chk({tg, "_done_cnt"}, dcnt, 1);
        chk({tg, "_done_idx"}, didx, p + 40);
        chk({tg, "_busy_first"}, int'(cb[s][0]), 1);
        // busy covers the LOAD cycle plus the whole frame, low in the done cycle.
        chk({tg, "_busy_cnt"}, bcnt, ftime + 1);
        if (didx >= 0) chk({tg, "_busy_at_done"}, int'(cb[s][didx]), 0);
    endtask

    initial begin
        int dcnt, d0, r1, bcnt;
        if_a.start = 1'b0;
        if_b.start = 1'b0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_txd_a", int'(if_a.txd), 1);
        chk("rst_busy_a", int'(if_a.busy), 0);
        chk("rst_done_a", int'(if_a.done), 0);
        chk("rst_txd_b", int'(if_b.txd), 1);
        chk("rst_busy_b", int'(if_b.busy), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single start pulse, GAP=2: 212-cycle frame
        drive_start(0, 1'b1);
        capture(260, 0, 0, -1, -1, -1);
        analyze(0, 2, 260, "single");
        repeat (5) @(negedge clk);

        // Start pulses during the frame are dropped
        drive_start(0, 1'b1);
        capture(480, 0, 0, 10, 100, 200);
        analyze(0, 2, 480, "ignore");
        repeat (5) @(negedge clk);

        // Start held high: frame 1 done at 213, taken again in IDLE at 214,
        // busy from 215, second done at 428; start drops at 400 so only two frames.
        drive_start(0, 1'b1);
        capture(700, 0, 400, -1, -1, -1);
        dcnt = 0; d0 = -1; r1 = -1;
        for (int i = 0; i < 700; i++) begin
            if (cd[0][i]) begin dcnt++; if (d0 < 0) d0 = i; end
            if (d0 >= 0 && r1 < 0 && i > d0 && cb[0][i]) r1 = i;
        end
        chk("held_done_cnt", dcnt, 2);
        chk("held_first_done", d0, 213);
        chk("held_restart", r1 - d0, 2);
        repeat (5) @(negedge clk);

        // Reset while 0xCC start bit is on the line (byte 2 starts at index 87)
        drive_start(0, 1'b1);
        capture(89, 0, 0, -1, -1, -1);
        chk("abort_pre_txd", int'(ct[0][88]), 0);
        chk("abort_pre_busy", int'(cb[0][88]), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_txd", int'(if_a.txd), 1);
        chk("abort_busy", int'(if_a.busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        capture(300, 0, 0, -1, -1, -1);
        dcnt = 0; bcnt = 0;
        for (int i = 0; i < 300; i++) begin
            if (cd[0][i]) dcnt++;
            if (cb[0][i] || !ct[0][i]) bcnt++;
        end
        chk("abort_no_done", dcnt, 0);
        chk("abort_quiet", bcnt, 0);
        drive_start(0, 1'b1);
        capture(260, 0, 0, -1, -1, -1);
        analyze(0, 2, 260, "after_abort");
        repeat (5) @(negedge clk);

        // GAP=0: one idle cycle between bytes, 204-cycle frame
        drive_start(1, 1'b1);
        capture(260, 1, 0, -1, -1, -1);
        analyze(1, 0, 260, "gap0");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
